// File: rtl/mux_nx1_scan.sv
// rtl/mux_nx1_scan.sv - N-channel W-bit selector with registered handshaked output, direct and auto-scan modes
// Optional build macro: MUX_SCAN_MASK_EN (scan mode skips channels whose en_mask bit is 0)
module mux_nx1_scan #(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int SW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] i,
    input  logic [SW-1:0]  s,
    input  logic           mode,
    input  logic [N-1:0]   en_mask,
    input  logic           load,
    output logic [W-1:0]   o,
    output logic [SW-1:0]  o_ch,
    output logic           o_valid,
    input  logic           o_ready,
    output logic           o_err
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Channel count widened by one bit so N == 2**SW still compares correctly
    localparam logic [SW:0] N_EXT = (SW+1)'(N);

    state_t        state_q;
    logic [W-1:0]  o_q;
    logic [SW-1:0] ch_q;
    logic          err_q;
    logic [SW-1:0] ptr_q;

    logic          tgt_exists;
    logic          tgt_err;
    logic [SW-1:0] tgt_ch;
    logic [SW-1:0] ptr_d;
    logic [W-1:0]  tgt_data;
    logic          slot_free;
    logic          accept;

    // Circular channel arithmetic: (p + off) mod N for off in 0..N
    function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] p, input int off);
        int t;
        t = int'(p) + off;
        if (t >= N) begin
            t = t - N;
        end
        return SW'(t);
    endfunction

`ifndef MUX_SCAN_MASK_EN
    // The enable mask has no effect when channel skipping is not built in
    logic unused_mask;
    assign unused_mask = ^en_mask;
`endif

    // Pick the target channel and the pointer value that follows a scan capture
    always_comb begin
        tgt_exists = 1'b0;
        tgt_err    = 1'b0;
        tgt_ch     = '0;
        ptr_d      = ptr_q;
        if (!mode) begin
            tgt_exists = 1'b1;
            tgt_ch     = s;
            tgt_err    = ({1'b0, s} >= N_EXT);
        end else begin
`ifdef MUX_SCAN_MASK_EN
            for (int off = 0; off < N; off++) begin
                if (!tgt_exists && en_mask[wrap_add(ptr_q, off)]) begin
                    tgt_exists = 1'b1;
                    tgt_ch     = wrap_add(ptr_q, off);
                end
            end
`else
            tgt_exists = 1'b1;
            tgt_ch     = ptr_q;
`endif
            ptr_d = wrap_add(tgt_ch, 1);
        end
    end

    // Data mux over the channel bank; an out-of-range direct select captures zero
    always_comb begin
        tgt_data = '0;
        for (int k = 0; k < N; k++) begin
            if (!tgt_err && (tgt_ch == SW'(k))) begin
                tgt_data = i[k*W +: W];
            end
        end
    end

    assign slot_free = (state_q == EMPTY) || o_ready;
    assign accept    = load && slot_free && tgt_exists;

    // Output slot FSM: capture on accept, drain on o_ready, pointer steps on scan captures
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            o_q     <= '0;
            ch_q    <= '0;
            err_q   <= 1'b0;
            ptr_q   <= '0;
        end else if (accept) begin
            state_q <= FULL;
            o_q     <= tgt_data;
            ch_q    <= tgt_ch;
            err_q   <= tgt_err;
            if (mode) begin
                ptr_q <= ptr_d;
            end
        end else if ((state_q == FULL) && o_ready) begin
            state_q <= EMPTY;
        end
    end

    assign o       = o_q;
    assign o_ch    = ch_q;
    assign o_err   = err_q;
    assign o_valid = (state_q == FULL);

endmodule

// File: tb/tb_mux_nx1_scan.sv
// tb/tb_mux_nx1_scan.sv - self-checking bench for mux_nx1_scan (N=8 main instance, N=6 range-error instance)
module tb_mux_nx1_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] i;
    logic [2:0]  s;
    logic        mode;
    logic [7:0]  en_mask;
    logic        load;
    logic [7:0]  o;
    logic [2:0]  o_ch;
    logic        o_valid;
    logic        o_ready;
    logic        o_err;

    logic [47:0] i6;
    logic [2:0]  s6;
    logic        mode6;
    logic [5:0]  en_mask6;
    logic        load6;
    logic [7:0]  o6;
    logic [2:0]  o_ch6;
    logic        o_valid6;
    logic        o_ready6;
    logic        o_err6;

    mux_nx1_scan #(.N(8), .W(8), .SW(3)) dut (
        .clk(clk), .rst(rst), .i(i), .s(s), .mode(mode), .en_mask(en_mask),
        .load(load), .o(o), .o_ch(o_ch), .o_valid(o_valid), .o_ready(o_ready), .o_err(o_err)
    );

    mux_nx1_scan #(.N(6), .W(8), .SW(3)) dut6 (
        .clk(clk), .rst(rst), .i(i6), .s(s6), .mode(mode6), .en_mask(en_mask6),
        .load(load6), .o(o6), .o_ch(o_ch6), .o_valid(o_valid6), .o_ready(o_ready6), .o_err(o_err6)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] o;
        logic [2:0] ch;
        logic       err;
    } exp_t;

    typedef struct {
        logic       ld;
        logic       rdy;
        logic [2:0] sel;
        logic       ev;
        logic [2:0] ech;
    } vec_t;

    exp_t       sb[$];
    vec_t       tbl[8];
    int         n_chk  = 0;
    int         n_fail = 0;

    logic       m_valid;
    logic [2:0] m_ptr;
    logic [7:0] m_o;
    logic [2:0] m_ch;
    logic [2:0] mseq[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset(input logic ld);
        rst = 1'b1; load = ld; o_ready = 1'b1; mode = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; load = 1'b0;
        chk("rst_o", 32'(o), 32'h0);
        chk("rst_o_ch", 32'(o_ch), 32'h0);
        chk("rst_o_valid", 32'(o_valid), 32'h0);
        chk("rst_o_err", 32'(o_err), 32'h0);
        m_valid = 1'b0; m_ptr = '0; m_o = '0; m_ch = '0;
        sb.delete();
    endtask

    // One clock of stimulus on the N=8 instance; the model decides acceptance and queues the expected sample
    task automatic cyc(input logic ld, input logic rdy, input logic md, input logic [2:0] sel,
                       input logic [7:0] msk, input logic [7:0] base);
        logic       acc;
        logic       ex;
        logic [2:0] tgt;
        exp_t       e;
        load = ld; o_ready = rdy; mode = md; s = sel; en_mask = msk;
        for (int k = 0; k < 8; k++) i[k*8 +: 8] = base + 8'(k);
        ex  = 1'b1;
        tgt = sel;
        if (md) begin
`ifdef MUX_SCAN_MASK_EN
            ex = 1'b0;
            for (int off = 0; off < 8; off++) begin
                if (!ex && msk[m_ptr + 3'(off)]) begin
                    ex  = 1'b1;
                    tgt = m_ptr + 3'(off);
                end
            end
`else
            tgt = m_ptr;
`endif
        end
        acc = ld && (!m_valid || rdy) && ex;
        if (acc) begin
            e.o = base + {5'b0, tgt}; e.ch = tgt; e.err = 1'b0;
            sb.push_back(e);
            if (md) m_ptr = tgt + 3'd1;
            m_valid = 1'b1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk); #1;
        chk("o_valid", 32'(o_valid), 32'(m_valid));
        if (acc) begin
            if (sb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL scoreboard_empty: got 0 entries expected 1");
            end else begin
                e = sb.pop_front();
                chk("sb_o", 32'(o), 32'(e.o));
                chk("sb_o_ch", 32'(o_ch), 32'(e.ch));
                chk("sb_o_err", 32'(o_err), 32'(e.err));
                m_o = e.o; m_ch = e.ch;
            end
        end else begin
            chk("held_o", 32'(o), 32'(m_o));
            chk("held_o_ch", 32'(o_ch), 32'(m_ch));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Direct-mode handshake table: {load, o_ready, s, expected o_valid, expected o_ch}
        tbl[0] = '{1'b1, 1'b0, 3'd5, 1'b1, 3'd5};
        tbl[1] = '{1'b0, 1'b0, 3'd5, 1'b1, 3'd5};
        tbl[2] = '{1'b1, 1'b0, 3'd3, 1'b1, 3'd5};
        tbl[3] = '{1'b0, 1'b1, 3'd3, 1'b0, 3'd5};
        tbl[4] = '{1'b0, 1'b1, 3'd3, 1'b0, 3'd5};
        tbl[5] = '{1'b1, 1'b1, 3'd3, 1'b1, 3'd3};
        tbl[6] = '{1'b1, 1'b1, 3'd6, 1'b1, 3'd6};
        tbl[7] = '{1'b0, 1'b1, 3'd6, 1'b0, 3'd6};
`ifdef MUX_SCAN_MASK_EN
        mseq[0] = 3'd2; mseq[1] = 3'd5; mseq[2] = 3'd7; mseq[3] = 3'd2; mseq[4] = 3'd5;
`else
        mseq[0] = 3'd0; mseq[1] = 3'd1; mseq[2] = 3'd2; mseq[3] = 3'd3; mseq[4] = 3'd4;
`endif
        i = '0; s = '0; mode = 1'b0; en_mask = 8'hff; load = 1'b0; o_ready = 1'b0;
        i6 = '0; s6 = '0; mode6 = 1'b0; en_mask6 = 6'h3f; load6 = 1'b0; o_ready6 = 1'b0;

        do_reset(1'b0);
        do_reset(1'b0);
        chk("rst6_o_valid", 32'(o_valid6), 32'h0);
        chk("rst6_o_err", 32'(o_err6), 32'h0);

        // Direct mode table with i channel k = 8'h10 + k
        for (int t = 0; t < 8; t++) begin
            cyc(tbl[t].ld, tbl[t].rdy, 1'b0, tbl[t].sel, 8'hff, 8'h10);
            chk("tbl_o_valid", 32'(o_valid), 32'(tbl[t].ev));
            chk("tbl_o_ch", 32'(o_ch), 32'(tbl[t].ech));
            if (t == 0) chk("direct_o_15", 32'(o), 32'h15);
        end

        // Scan, load and o_ready held: o_ch 0..7,0,1 with o_valid continuously high
        for (int j = 0; j < 10; j++) begin
            cyc(1'b1, 1'b1, 1'b1, 3'd0, 8'hff, 8'h30 + 8'(j));
            chk("scan_o_ch", 32'(o_ch), 32'(j % 8));
            chk("scan_o_valid", 32'(o_valid), 32'h1);
        end
        cyc(1'b0, 1'b1, 1'b1, 3'd0, 8'hff, 8'h30);

        // Mask sequence from a fresh pointer
        do_reset(1'b0);
        for (int j = 0; j < 5; j++) begin
            cyc(1'b1, 1'b1, 1'b1, 3'd0, 8'b1010_0100, 8'h40 + 8'(j));
            chk("mask_seq", 32'(o_ch), 32'(mseq[j]));
        end
        cyc(1'b0, 1'b1, 1'b1, 3'd0, 8'hff, 8'h40);
`ifdef MUX_SCAN_MASK_EN
        for (int j = 0; j < 3; j++) begin
            cyc(1'b1, 1'b1, 1'b1, 3'd0, 8'h00, 8'h50);
            chk("mask0_o_valid", 32'(o_valid), 32'h0);
        end
        cyc(1'b1, 1'b1, 1'b1, 3'd0, 8'hff, 8'h60);
        chk("mask0_ptr_kept", 32'(o_ch), 32'h6);
`endif

        // Backpressure: held sample and frozen pointer while o_ready is low
        do_reset(1'b0);
        cyc(1'b1, 1'b0, 1'b0, 3'd5, 8'hff, 8'h10);
        for (int j = 0; j < 3; j++) begin
            cyc(1'b1, 1'b0, 1'b1, 3'd0, 8'hff, 8'h70 + 8'(j * 4));
            chk("bp_o_held", 32'(o), 32'h15);
            chk("bp_o_ch_held", 32'(o_ch), 32'h5);
        end
        cyc(1'b1, 1'b1, 1'b1, 3'd0, 8'hff, 8'h90);
        chk("bp_release_ch", 32'(o_ch), 32'h0);
        chk("bp_release_o", 32'(o), 32'h90);

        // Reset while FULL with load asserted, then scan restarts at channel 0
        cyc(1'b1, 1'b1, 1'b1, 3'd0, 8'hff, 8'ha0);
        chk("pre_rst_valid", 32'(o_valid), 32'h1);
        do_reset(1'b1);
        cyc(1'b1, 1'b0, 1'b1, 3'd0, 8'hff, 8'hb0);
        chk("post_rst_ch", 32'(o_ch), 32'h0);
        chk("post_rst_o", 32'(o), 32'hb0);

        // N=6: out-of-range direct select, then a valid one clears o_err
        for (int k = 0; k < 6; k++) i6[k*8 +: 8] = 8'h20 + 8'(k);
        s6 = 3'd7; load6 = 1'b1; o_ready6 = 1'b0;
        @(posedge clk); #1;
        chk("n6_err_o", 32'(o6), 32'h0);
        chk("n6_err_ch", 32'(o_ch6), 32'h7);
        chk("n6_err_flag", 32'(o_err6), 32'h1);
        chk("n6_err_valid", 32'(o_valid6), 32'h1);
        s6 = 3'd2; load6 = 1'b1; o_ready6 = 1'b1;
        @(posedge clk); #1;
        chk("n6_ok_o", 32'(o6), 32'h22);
        chk("n6_ok_ch", 32'(o_ch6), 32'h2);
        chk("n6_ok_err", 32'(o_err6), 32'h0);
        load6 = 1'b0;
        @(posedge clk); #1;
        chk("n6_drain_valid", 32'(o_valid6), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
